// File: rtl/tick_period_meter_if.sv
// Result channel of the tick period meter: measured period plus mismatch flag,
// moved with a valid/ready handshake from the meter (master) to its consumer.
interface tick_period_meter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] period_out;
  logic             period_err;
  logic             period_valid;
  logic             period_ready;

  modport master (
    output period_out,
    output period_err,
    output period_valid,
    input  period_ready
  );

  modport slave (
    input  period_out,
    input  period_err,
    input  period_valid,
    output period_ready
  );
endinterface

// File: rtl/tick_period_meter.sv
// Measures the cycle distance between pulse_in events and flags deviations from a programmed period.
// Result appears one edge after the event; a stalled consumer keeps the old result and new ones are dropped (sticky overrun).
module tick_period_meter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 pulse_in,
  input  logic                 exp_set,
  input  logic [WIDTH-1:0]     exp_val,
  input  logic [WIDTH-1:0]     timeout_val,
  tick_period_meter_if.master  res,
  output logic                 overrun,
  output logic                 timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             tmo_q, tmo_d;
  logic             result_new;
  logic [WIDTH-1:0] cnt_inc;

  // Saturate instead of wrapping so a very long gap never aliases to a short period.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_d      = exp_set ? exp_val : exp_q;
    out_d      = out_q;
    err_d      = err_q;
    vld_d      = vld_q;
    ovr_d      = ovr_q;
    tmo_d      = tmo_q;
    result_new = 1'b0;

    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d = ARMED;
          cnt_d   = WIDTH'(1);
        end
      end
      ARMED: begin
        if (pulse_in) begin
          result_new = 1'b1;
          cnt_d      = WIDTH'(1);
        end else if ((timeout_val != '0) && (cnt_q == timeout_val)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase

    if (vld_q && res.period_ready) begin
      vld_d = 1'b0;
    end
    // A result landing on a stalled slot is lost; one landing on a transfer replaces it.
    if (result_new) begin
      if (vld_q && !res.period_ready) begin
        ovr_d = 1'b1;
      end else begin
        out_d = cnt_q;
        err_d = (cnt_q != exp_q);
        vld_d = 1'b1;
      end
    end

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      exp_d   = exp_q;
      out_d   = '0;
      err_d   = 1'b0;
      vld_d   = 1'b0;
      ovr_d   = 1'b0;
      tmo_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      out_q   <= out_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign res.period_out   = out_q;
  assign res.period_err   = err_q;
  assign res.period_valid = vld_q;
  assign overrun          = ovr_q;
  assign timeout          = tmo_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: timestamp-based reference model feeding a result scoreboard,
// directed scenarios for the notable corner cases, then randomized traffic.
module tb_tick_period_meter;
  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  typedef struct packed {
    logic [W-1:0] per;
    logic         err;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         pulse_in;
  logic         exp_set;
  logic [W-1:0] exp_val;
  logic [W-1:0] timeout_val;
  logic         overrun;
  logic         timeout;

  tick_period_meter_if #(.WIDTH(W)) res_if ();

  tick_period_meter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .pulse_in    (pulse_in),
    .exp_set     (exp_set),
    .exp_val     (exp_val),
    .timeout_val (timeout_val),
    .res         (res_if.master),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int   checks    = 0;
  int   failures  = 0;
  int   delivered = 0;
  res_t sb[$];

  // Reference model state: time of last event instead of a running counter.
  int           cyc      = 0;
  int           last_evt = 0;
  int           el;
  bit           m_have   = 1'b0;
  bit           m_full   = 1'b0;
  bit           m_ovr    = 1'b0;
  bit           m_tmo    = 1'b0;
  bit           newr;
  logic [W-1:0] m_exp    = '0;
  logic [W-1:0] per;
  res_t         got;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step(input logic p);
    @(posedge clk);
    #1;
    pulse_in = p;
    exp_set  = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic periodic(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1);
      repeat (p - 1) step(1'b0);
    end
  endtask

  task automatic set_exp(input logic [W-1:0] v);
    @(posedge clk);
    #1;
    pulse_in = 1'b0;
    clear    = 1'b0;
    exp_set  = 1'b1;
    exp_val  = v;
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1;
    pulse_in = 1'b0;
    exp_set  = 1'b0;
    clear    = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    clear       = 1'b0;
    pulse_in    = 1'b0;
    exp_set     = 1'b0;
    exp_val     = '0;
    timeout_val = '0;
    res_if.period_ready = 1'b1;

    fork
      // Reference model: period = cycles since previous event, saturated to W bits.
      forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
          m_have = 1'b0;
          m_full = 1'b0;
          m_ovr  = 1'b0;
          m_tmo  = 1'b0;
          m_exp  = '0;
          sb.delete();
        end else begin
          if (clear) begin
            m_have = 1'b0;
            m_full = 1'b0;
            m_ovr  = 1'b0;
            m_tmo  = 1'b0;
            sb.delete();
          end else begin
            el   = cyc - last_evt;
            per  = W'((el >= MAXV) ? MAXV : el);
            newr = 1'b0;
            if (pulse_in) begin
              newr     = m_have;
              m_have   = 1'b1;
              last_evt = cyc;
            end else if (m_have && timeout_val != '0 && per == timeout_val) begin
              m_tmo  = 1'b1;
              m_have = 1'b0;
            end
            if (newr && m_full && !res_if.period_ready) begin
              m_ovr = 1'b1;
            end else if (newr) begin
              sb.push_back('{per: per, err: (per != m_exp)});
              m_full = 1'b1;
            end else if (m_full && res_if.period_ready) begin
              m_full = 1'b0;
            end
            if (exp_set) m_exp = exp_val;
          end
          cyc++;
        end
      end
      // Monitor: compares flags every cycle and pops a result at each handshake.
      forever begin
        @(negedge clk);
        if (reset === 1'b1) begin
          chk("valid", 32'(res_if.period_valid), 32'(m_full));
          chk("overrun", 32'(overrun), 32'(m_ovr));
          chk("timeout", 32'(timeout), 32'(m_tmo));
          if (res_if.period_valid && res_if.period_ready) begin
            if (sb.size() == 0) begin
              chk("unexpected_result", 32'(1), 32'(0));
            end else begin
              got = sb.pop_front();
              chk("period_out", 32'(res_if.period_out), 32'(got.per));
              chk("period_err", 32'(res_if.period_err), 32'(got.err));
              delivered++;
            end
          end
        end
      end
    join_none

    @(posedge clk);
    #1;
    chk("rst_period_out", 32'(res_if.period_out), 32'(0));
    chk("rst_period_err", 32'(res_if.period_err), 32'(0));
    chk("rst_valid", 32'(res_if.period_valid), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    chk("rst_timeout", 32'(timeout), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Exact period: first pulse arms only, later ones report 10 with no error.
    set_exp(W'(10));
    periodic(10, 3);
    step(1'b1);
    step(1'b0);
    #1;
    chk("p10_valid", 32'(res_if.period_valid), 32'(1));
    chk("p10_out", 32'(res_if.period_out), 32'(10));
    chk("p10_err", 32'(res_if.period_err), 32'(0));

    // Period 12 against expected 10.
    do_clear();
    periodic(12, 3);
    step(1'b1);
    step(1'b0);
    #1;
    chk("p12_out", 32'(res_if.period_out), 32'(12));
    chk("p12_err", 32'(res_if.period_err), 32'(1));

    // Stalled consumer: first result held, later ones dropped.
    do_clear();
    res_if.period_ready = 1'b0;
    periodic(5, 4);
    chk("ovr_out", 32'(res_if.period_out), 32'(5));
    chk("ovr_valid", 32'(res_if.period_valid), 32'(1));
    chk("ovr_flag", 32'(overrun), 32'(1));
    res_if.period_ready = 1'b1;
    repeat (3) step(1'b0);
    chk("ovr_drain_valid", 32'(res_if.period_valid), 32'(0));

    // Timeout: silence past 20 cycles returns to IDLE, next pulse only re-arms.
    do_clear();
    timeout_val = W'(20);
    periodic(8, 2);
    repeat (25) step(1'b0);
    chk("tmo_flag", 32'(timeout), 32'(1));
    step(1'b1);
    step(1'b0);
    #1;
    chk("tmo_rearm_valid", 32'(res_if.period_valid), 32'(0));
    repeat (5) step(1'b0);
    step(1'b1);
    step(1'b0);
    #1;
    chk("tmo_resume_out", 32'(res_if.period_out), 32'(7));
    chk("tmo_resume_valid", 32'(res_if.period_valid), 32'(1));
    timeout_val = '0;

    // Pulse held high: period 1 every cycle.
    do_clear();
    repeat (10) step(1'b1);
    #1;
    chk("cont_out", 32'(res_if.period_out), 32'(1));
    chk("cont_valid", 32'(res_if.period_valid), 32'(1));
    step(1'b0);

    // Long gap saturates at all-ones.
    do_clear();
    step(1'b1);
    repeat (300) step(1'b0);
    step(1'b1);
    step(1'b0);
    #1;
    chk("sat_out", 32'(res_if.period_out), 32'(MAXV));
    chk("sat_err", 32'(res_if.period_err), 32'(1));

    // Asynchronous reset while a result is held and counting is in progress.
    do_clear();
    res_if.period_ready = 1'b0;
    periodic(4, 2);
    step(1'b0);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_out", 32'(res_if.period_out), 32'(0));
    chk("arst_err", 32'(res_if.period_err), 32'(0));
    chk("arst_valid", 32'(res_if.period_valid), 32'(0));
    chk("arst_overrun", 32'(overrun), 32'(0));
    chk("arst_timeout", 32'(timeout), 32'(0));
    reset = 1'b1;
    res_if.period_ready = 1'b1;

    // Clear coincident with an event wins: no result, then a fresh arm.
    step(1'b1);
    repeat (3) step(1'b0);
    @(posedge clk);
    #1;
    clear    = 1'b1;
    pulse_in = 1'b1;
    step(1'b0);
    #1;
    chk("clr_evt_valid", 32'(res_if.period_valid), 32'(0));
    step(1'b1);
    repeat (3) step(1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      pulse_in            = ($urandom_range(0, 4) == 0);
      res_if.period_ready = ($urandom_range(0, 3) != 0);
      exp_set             = ($urandom_range(0, 30) == 0);
      exp_val             = W'($urandom_range(1, 12));
      clear               = ($urandom_range(0, 150) == 0);
      if ($urandom_range(0, 60) == 0)
        timeout_val = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom_range(4, 15));
    end

    res_if.period_ready = 1'b1;
    repeat (5) step(1'b0);
    chk("sb_drain", 32'(sb.size()), 32'(0));
    chk("delivered_nonzero", 32'(delivered > 0), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tick_period_meter.md
TICK_PERIOD_METER -- requirements
Module: tick_period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of period, expected and timeout values.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port clear  input  1  synchronous clear of FSM, output register and sticky flags.
REQ-005 SHALL have port pulse_in  input  1  tick from periodic counter; every cycle sampled high is one event.
REQ-006 SHALL have port exp_set  input  1  load strobe for the expected period.
REQ-007 SHALL have port exp_val  input  WIDTH  expected period value, captured when exp_set=1.
REQ-008 SHALL have port timeout_val  input  WIDTH  timeout in cycles since last event; 0 disables timeout.
REQ-009 SHALL have port period_out  output  WIDTH  measured period in clk cycles.
REQ-010 SHALL have port period_err  output  1  period_out != expected register at time of measurement.
REQ-011 SHALL have port period_valid  output  1  period_out/period_err hold a result.
REQ-012 SHALL have port period_ready  input  1  consumer accepts result when valid and ready are both 1.
REQ-013 SHALL have port overrun  output  1  sticky: a result was dropped.
REQ-014 SHALL have port timeout  output  1  sticky: timeout occurred.

Function
REQ-015 SHALL hold the expected register; exp_set=1 loads exp_val next edge, otherwise the register holds its value.
REQ-016 SHALL implement FSM states IDLE (no reference event) and ARMED (counting since last event).
REQ-017 SHALL, in IDLE, on event: move to ARMED, set cnt=1, produce no result.
REQ-018 SHALL, in ARMED without event, increment cnt by 1, saturating at all-ones (no wrap).
REQ-019 SHALL, in ARMED on event, produce result period=cnt, set cnt=1, stay ARMED; events P cycles apart yield period P.
REQ-020 SHALL compute period_err as (cnt != expected register) using the expected value present in the event cycle.
REQ-021 SHALL present a result on period_out/period_err with period_valid=1 on the edge following the event cycle (1-cycle latency).
REQ-022 SHALL keep period_out/period_err stable while period_valid=1 and period_ready=0.
REQ-023 SHALL deassert period_valid the edge after valid&ready unless a new result loads the same edge.
REQ-024 SHALL, when a new result arrives while valid=1 and ready=0, keep the old result, drop the new, and set overrun.
REQ-025 SHALL, when a new result arrives in the same cycle as valid&ready, load the new result with valid=1 and no overrun.
REQ-026 SHALL, in ARMED with timeout_val!=0, cnt==timeout_val and no event that cycle, set timeout and go to IDLE (no result).
REQ-027 SHALL give an event in the same cycle as the timeout condition priority: normal result, no timeout.
REQ-028 SHALL give clear priority over every other action in the same cycle: state IDLE, cnt=0, valid=0, overrun=0, timeout=0; expected register unchanged.
REQ-029 SHALL keep overrun and timeout set until clear or reset.

Reset
REQ-030 SHALL, while reset=0, immediately force state IDLE, cnt=0, expected register=0, period_out=0, period_err=0, period_valid=0, overrun=0, timeout=0.
REQ-031 SHALL resume on the first rising clk edge after reset returns to 1; an event on that edge is treated as an IDLE first event.

Verification
REQ-032 SHALL cover: exp_val=10 loaded, pulse_in high one cycle every 10 cycles, ready=1 -> after second pulse, period_out=10, period_err=0, valid high one cycle per pulse.
REQ-033 SHALL cover: exp=10, pulses every 12 cycles -> period_out=12, period_err=1; first pulse after reset yields no result.
REQ-034 SHALL cover: ready=0, pulses every 5 cycles, four pulses -> period_out=5 held from first result, overrun=1; ready=1 -> one transfer, valid drops.
REQ-035 SHALL cover: timeout_val=20, pulses stop after event -> timeout=1 and IDLE after cnt reaches 20; next pulse produces no result, following pulse resumes.
REQ-036 SHALL cover: pulse_in held high continuously, ready=1 -> period_out=1 every cycle after the first.
REQ-037 SHALL cover: reset driven low mid-count with valid=1 -> all outputs 0 immediately without clock edge; clear with coincident event -> IDLE, no result.
